hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 98 +++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Purpose: D-stage hazard detection. It tracks the destination registers of the
//          instructions in stages E..W, and it tracks the mult/div busy window.
// Latency: all outputs are combinational from the current inputs and the
//          registered scoreboard state.
// Backpressure: stall freezes PC/D. While it is high, a bubble enters stage 1
//          and the older entries keep shifting.
// Ports:   clk, reset (sync, active-low); D-stage source/destination
//          descriptors; d_md_use; e_md_start/e_md_is_div; stall,
//          fwd_rs_sel/fwd_rt_sel (0=GRF, k=stage k), md_busy.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int SW       = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs_addr,
    input  logic [4:0]    d_rt_addr,
    input  logic          d_rs_use,
    input  logic          d_rt_use,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic          d_reg_write,
    input  logic [4:0]    d_dst_addr,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_use,
    input  logic          e_md_start,
    input  logic          e_md_is_div,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic          md_busy
);

    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    // Entry k holds the instruction k stages past D (1=E ... NSTAGE=W).
    logic          ent_vld  [1:NSTAGE];
    logic [4:0]    ent_addr [1:NSTAGE];
    logic [TW-1:0] ent_tnew [1:NSTAGE];
    logic [CW-1:0] md_cnt;

    logic rs_hz;
    logic rt_hz;

    // The loop walks from oldest to youngest. The last match wins the select,
    // so the youngest producer decides. If that producer is not ready yet,
    // the select is 0, even when an older stage holds a finished copy.
    always_comb begin
        rs_hz      = 1'b0;
        rt_hz      = 1'b0;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (d_rs_use && ent_vld[k] && (ent_addr[k] == d_rs_addr) && (d_rs_addr != 5'd0)) begin
                if (ent_tnew[k] > d_rs_tuse) rs_hz = 1'b1;
                fwd_rs_sel = (ent_tnew[k] == '0) ? SW'(k) : '0;
            end
            if (d_rt_use && ent_vld[k] && (ent_addr[k] == d_rt_addr) && (d_rt_addr != 5'd0)) begin
                if (ent_tnew[k] > d_rt_tuse) rt_hz = 1'b1;
                fwd_rt_sel = (ent_tnew[k] == '0) ? SW'(k) : '0;
            end
        end
    end

    assign md_busy = e_md_start || (md_cnt != '0);
    assign stall   = rs_hz || rt_hz || (d_md_use && md_busy);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                ent_vld[k]  <= 1'b0;
                ent_addr[k] <= 5'd0;
                ent_tnew[k] <= '0;
            end
            md_cnt <= '0;
        end else begin
            // A stalled D instruction stays in D, so stage 1 receives a bubble.
            ent_vld[1]  <= !stall && d_reg_write && (d_dst_addr != 5'd0);
            ent_addr[1] <= d_dst_addr;
            ent_tnew[1] <= d_tnew;
            for (int k = 2; k <= NSTAGE; k++) begin
                ent_vld[k]  <= ent_vld[k-1];
                ent_addr[k] <= ent_addr[k-1];
                ent_tnew[k] <= (ent_tnew[k-1] != '0) ? ent_tnew[k-1] - TW'(1) : '0;
            end
            // A new start always reloads the counter, even mid-operation.
            if (e_md_start)
                md_cnt <= e_md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CW'(1);
        end
    end

endmodule
